// File: rtl/matriz_leds_varredura.sv
// matriz_leds_varredura: LED-matrix column scanner with blanking gaps and a multi-page frame buffer
module matriz_leds_varredura #(
  parameter int COLUNAS      = 5,
  parameter int LINHAS       = 7,
  parameter int PAGINAS      = 2,
  parameter int TEMPO_COLUNA = 4,
  parameter int TEMPO_BRANCO = 1,
  parameter int TEMPO_PAGINA = 2
) (
  input  logic                         frequencia_display,
  input  logic                         reset_n,
  input  logic                         escreve,
  input  logic [$clog2(PAGINAS)-1:0]   escreve_pagina,
  input  logic [$clog2(COLUNAS)-1:0]   escreve_coluna,
  input  logic [LINHAS-1:0]            escreve_dado,
  input  logic                         modo_auto,
  input  logic [$clog2(PAGINAS)-1:0]   seletor,
  output logic [COLUNAS-1:0]           col,
  output logic [LINHAS-1:0]            linhas,
  output logic [$clog2(PAGINAS)-1:0]   pagina_atual,
  output logic                         fim_quadro
);
  localparam int CW   = $clog2(COLUNAS);
  localparam int PW   = $clog2(PAGINAS);
  localparam int CNTW = $clog2((TEMPO_COLUNA > TEMPO_BRANCO ? TEMPO_COLUNA : TEMPO_BRANCO) + 1);
  localparam int FW   = $clog2(TEMPO_PAGINA + 1);

  typedef enum logic {BRANCO, ACESO} estado_t;

  estado_t             r_estado, w_estado;
  logic [CNTW-1:0]     r_cnt, w_cnt;
  logic [CW-1:0]       r_coluna, w_coluna;
  logic [PW-1:0]       r_pagina, w_pagina;
  logic [FW-1:0]       r_quadros, w_quadros, w_prox_quadros;
  logic [COLUNAS-1:0]  r_col, w_col;
  logic [LINHAS-1:0]   r_linhas, w_linhas;
  logic                r_fim;
  logic                w_ultimo, w_acende, w_apaga, w_quadro, w_vira, w_sel_ok, w_escreve_ok;
  logic [LINHAS-1:0]   r_buf [PAGINAS][COLUNAS];

  // index checks are done one bit wider so non-power-of-two sizes reject the unused codes
  assign w_sel_ok     = {1'b0, seletor} < (PW+1)'(PAGINAS);
  assign w_escreve_ok = escreve && ({1'b0, escreve_pagina} < (PW+1)'(PAGINAS))
                        && ({1'b0, escreve_coluna} < (CW+1)'(COLUNAS));

  always_comb begin
    w_ultimo       = (r_estado == BRANCO) ? (r_cnt == CNTW'(TEMPO_BRANCO - 1)) : (r_cnt == CNTW'(TEMPO_COLUNA - 1));
    w_acende       = (r_estado == BRANCO) && w_ultimo;
    w_apaga        = (r_estado == ACESO) && w_ultimo;
    w_quadro       = w_apaga && (r_coluna == CW'(COLUNAS - 1));
    w_estado       = w_ultimo ? ((r_estado == BRANCO) ? ACESO : BRANCO) : r_estado;
    w_cnt          = w_ultimo ? '0 : r_cnt + 1'b1;
    w_col          = w_acende ? COLUNAS'(1) << r_coluna : w_apaga ? '0 : r_col;
    w_linhas       = w_acende ? r_buf[r_pagina][r_coluna] : w_apaga ? '0 : r_linhas;
    w_coluna       = w_apaga ? ((r_coluna == CW'(COLUNAS - 1)) ? '0 : r_coluna + 1'b1) : r_coluna;
    w_prox_quadros = r_quadros + 1'b1;
    w_vira         = w_prox_quadros == FW'(TEMPO_PAGINA);
    w_quadros      = !w_quadro ? r_quadros : (!modo_auto || w_vira) ? '0 : w_prox_quadros;
    w_pagina       = !w_quadro ? r_pagina
                   : !modo_auto ? (w_sel_ok ? seletor : r_pagina)
                   : !w_vira ? r_pagina
                   : (r_pagina == PW'(PAGINAS - 1)) ? '0 : r_pagina + 1'b1;
  end

  always_ff @(posedge frequencia_display or negedge reset_n) begin
    if (!reset_n) begin
      r_estado  <= BRANCO;
      r_cnt     <= '0;
      r_coluna  <= '0;
      r_pagina  <= '0;
      r_quadros <= '0;
      r_col     <= '0;
      r_linhas  <= '0;
      r_fim     <= 1'b0;
    end else begin
      r_estado  <= w_estado;
      r_cnt     <= w_cnt;
      r_coluna  <= w_coluna;
      r_pagina  <= w_pagina;
      r_quadros <= w_quadros;
      r_col     <= w_col;
      r_linhas  <= w_linhas;
      r_fim     <= w_quadro;
    end
  end

  always_ff @(posedge frequencia_display or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PAGINAS; p++)
        for (int c = 0; c < COLUNAS; c++)
          r_buf[p][c] <= '0;
    end else if (w_escreve_ok) begin
      r_buf[escreve_pagina][escreve_coluna] <= escreve_dado;
    end
  end

  assign col          = r_col;
  assign linhas       = r_linhas;
  assign pagina_atual = r_pagina;
  assign fim_quadro   = r_fim;
endmodule
